// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage definitions: ALU opcode encoding, mul/div FSM states
// and the single-step restoring-division helper.
package rv32_pkg;

  localparam int ALU_CONTROL_WIDTH = 5;

  typedef enum logic [ALU_CONTROL_WIDTH-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_LUI    = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_control_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // M-ops occupy codes 16..23; divides are 20..23 and bit 1 selects remainder.
  function automatic logic is_mop(input logic [ALU_CONTROL_WIDTH-1:0] c);
    return (c[4:3] == 2'b10);
  endfunction

  function automatic logic is_div_op(input logic [ALU_CONTROL_WIDTH-1:0] c);
    return (c[4:2] == 3'b101);
  endfunction

  function automatic logic is_signed_div(input logic [ALU_CONTROL_WIDTH-1:0] c);
    return (c == ALU_DIV) || (c == ALU_REM);
  endfunction

  // One restoring step: returns {remainder, quotient} after shifting in quot[31].
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quot,
                                           input logic [31:0] dvs);
    logic [32:0] sh;
    logic [32:0] diff;
    sh   = {rem, quot[31]};
    diff = sh - {1'b0, dvs};
    if (diff[32]) begin
      return {sh[31:0], quot[30:0], 1'b0};
    end else begin
      return {diff[31:0], quot[30:0], 1'b1};
    end
  endfunction

endpackage

// File: rtl/rv32_div_core.sv
// Iterative 32-bit unsigned restoring divider. The start edge performs the first
// step, so busy_o stays high for exactly 31 further cycles.
module rv32_div_core
  import rv32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        busy_o
);

  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic [63:0] w_first;
  logic [63:0] w_next;

  assign w_first = div_step(32'd0, dividend_i, divisor_i);
  assign w_next  = div_step(r_rem, r_quot, r_div);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_quot <= 32'd0;
      r_rem  <= 32'd0;
      r_div  <= 32'd0;
      r_cnt  <= 6'd0;
      r_busy <= 1'b0;
    end else if (start_i) begin
      r_rem  <= w_first[63:32];
      r_quot <= w_first[31:0];
      r_div  <= divisor_i;
      r_cnt  <= 6'd31;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_next[63:32];
      r_quot <= w_next[31:0];
      r_cnt  <= r_cnt - 6'd1;
      r_busy <= (r_cnt != 6'd1);
    end
  end

  assign quotient_o  = r_quot;
  assign remainder_o = r_rem;
  assign busy_o      = r_busy;

endmodule

// File: rtl/rv32_muldiv.sv
// Multi-cycle RV32M execute unit: one-cycle multiplier, 32-step divider, with
// divide-by-zero and signed overflow resolved at start.
module rv32_muldiv
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ALU_CONTROL_WIDTH-1:0] alu_control_i,
  input  logic [XLEN-1:0]              read_data_1_i,
  input  logic [XLEN-1:0]              read_data_2_i,
  output logic                         running_o,
  output logic                         done_o,
  output logic [XLEN-1:0]              result_o
);

  muldiv_state_t r_state;
  logic [ALU_CONTROL_WIDTH-1:0] r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_running;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_mop;
  logic        w_div_op;
  logic        w_sdiv;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_div_start;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [31:0] w_special;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_busy;
  logic [31:0] w_div_result;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_mul_result;

  assign w_mop       = is_mop(alu_control_i);
  assign w_div_op    = is_div_op(alu_control_i);
  assign w_sdiv      = is_signed_div(alu_control_i);
  assign w_div_zero  = (read_data_2_i == 32'd0);
  assign w_ovf       = w_sdiv && (read_data_1_i == 32'h8000_0000) && (read_data_2_i == 32'hFFFF_FFFF);
  assign w_div_start = (r_state == IDLE) && w_mop && w_div_op && !w_div_zero && !w_ovf;
  assign w_abs1      = (w_sdiv && read_data_1_i[31]) ? (32'd0 - read_data_1_i) : read_data_1_i;
  assign w_abs2      = (w_sdiv && read_data_2_i[31]) ? (32'd0 - read_data_2_i) : read_data_2_i;

  // Results for operations that never enter the divider.
  always_comb begin
    w_special = 32'd0;
    if (w_div_zero) begin
      w_special = alu_control_i[1] ? read_data_1_i : 32'hFFFF_FFFF;
    end else begin
      w_special = alu_control_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  rv32_div_core u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (w_div_start),
    .dividend_i  (w_abs1),
    .divisor_i   (w_abs2),
    .quotient_o  (w_quot),
    .remainder_o (w_rem),
    .busy_o      (w_div_busy)
  );

  assign w_div_result = r_op[1] ? (r_neg_r ? (32'd0 - w_rem)  : w_rem)
                                : (r_neg_q ? (32'd0 - w_quot) : w_quot);

  // Sign-extend to 64 bits so a plain unsigned multiply yields the two's-complement product.
  assign w_a_ext      = {{32{((r_op == ALU_MULH) || (r_op == ALU_MULHSU)) && r_a[31]}}, r_a};
  assign w_b_ext      = {{32{(r_op == ALU_MULH) && r_b[31]}}, r_b};
  assign w_prod       = w_a_ext * w_b_ext;
  assign w_mul_result = (r_op == ALU_MUL) ? w_prod[31:0] : w_prod[63:32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_op      <= 5'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mop) begin
            r_op    <= alu_control_i;
            r_a     <= read_data_1_i;
            r_b     <= read_data_2_i;
            r_neg_q <= w_sdiv && (read_data_1_i[31] ^ read_data_2_i[31]);
            r_neg_r <= w_sdiv && read_data_1_i[31];
            if (!w_div_op) begin
              r_state   <= MUL;
              r_running <= 1'b1;
            end else if (w_div_zero || w_ovf) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= w_special;
            end else begin
              r_state   <= DIV;
              r_running <= 1'b1;
            end
          end
        end
        MUL: begin
          r_state   <= DONE;
          r_done    <= 1'b1;
          r_running <= 1'b0;
          r_result  <= w_mul_result;
        end
        DIV: begin
          if (!w_div_busy) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_running <= 1'b0;
            r_result  <= w_div_result;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign running_o = r_running;
  assign done_o    = r_done;
  assign result_o  = r_result;

endmodule

// File: tb/tb_rv32_muldiv.sv
// Directed table-driven bench for rv32_muldiv: results, start-to-done latency,
// input isolation mid-op and asynchronous reset mid-divide.
module tb_rv32_muldiv;
  import rv32_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  alu_control;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        running;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  rv32_muldiv #(.XLEN(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alu_control_i (alu_control),
    .read_data_1_i (rd1),
    .read_data_2_i (rd2),
    .running_o     (running),
    .done_o        (done),
    .result_o      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one op; optionally swap in MUL 20,5 after the start edge to prove isolation.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm, input bit swap);
    int cnt;
    bit seen;
    @(negedge clk);
    alu_control = op;
    rd1 = a;
    rd2 = b;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 1) begin
        if (swap) begin
          alu_control = ALU_MUL;
          rd1 = 32'd20;
          rd2 = 32'd5;
        end else begin
          alu_control = ALU_ADD;
        end
        if (lat > 1) chk({nm, " running"}, {31'd0, running}, 32'd1);
      end
      if (done) seen = 1'b1;
    end
    alu_control = ALU_ADD;
    chk({nm, " latency"}, cnt, lat);
    chk({nm, " result"}, result, exp);
    chk({nm, " running@done"}, {31'd0, running}, 32'd0);
    @(posedge clk);
    #1;
    chk({nm, " done pulse"}, {31'd0, done}, 32'd0);
    chk({nm, " result held"}, result, exp);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{ALU_MUL,    32'd20,          32'd5,          32'd100,         2,  "MUL 20*5"},
      '{ALU_MUL,    32'hFFFF_FFFD,   32'd7,          32'hFFFF_FFEB,   2,  "MUL -3*7"},
      '{ALU_MULH,   32'hFFFF_FFFF,   32'hFFFF_FFFF,  32'h0000_0000,   2,  "MULH -1*-1"},
      '{ALU_MULH,   32'h8000_0000,   32'h8000_0000,  32'h4000_0000,   2,  "MULH min*min"},
      '{ALU_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF,  32'hFFFF_FFFE,   2,  "MULHU -1*-1"},
      '{ALU_MULHSU, 32'hFFFF_FFFF,   32'd2,          32'hFFFF_FFFF,   2,  "MULHSU -1*2"},
      '{ALU_REM,    32'd600,         32'd27,         32'd6,           33, "REM 600,27"},
      '{ALU_DIV,    32'd600,         32'd27,         32'd22,          33, "DIV 600,27"},
      '{ALU_REM,    32'hFFFF_EAA9,   32'd31,         32'hFFFF_FFF9,   33, "REM -5463,31"},
      '{ALU_DIV,    32'd7,           32'hFFFF_FFFE,  32'hFFFF_FFFD,   33, "DIV 7,-2"},
      '{ALU_REM,    32'd7,           32'hFFFF_FFFE,  32'd1,           33, "REM 7,-2"},
      '{ALU_DIVU,   32'hFFFF_FFFF,   32'd2,          32'h7FFF_FFFF,   33, "DIVU max,2"},
      '{ALU_REMU,   32'd100,         32'd7,          32'd2,           33, "REMU 100,7"},
      '{ALU_DIVU,   32'h8000_0000,   32'hFFFF_FFFF,  32'd0,           33, "DIVU min,max"},
      '{ALU_DIVU,   32'd1234,        32'd0,          32'hFFFF_FFFF,   1,  "DIVU x,0"},
      '{ALU_REMU,   32'd7,           32'd0,          32'd7,           1,  "REMU 7,0"},
      '{ALU_DIV,    32'd5,           32'd0,          32'hFFFF_FFFF,   1,  "DIV 5,0"},
      '{ALU_REM,    32'hFFFF_FFF7,   32'd0,          32'hFFFF_FFF7,   1,  "REM -9,0"},
      '{ALU_DIV,    32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,   1,  "DIV ovf"},
      '{ALU_REM,    32'h8000_0000,   32'hFFFF_FFFF,  32'd0,           1,  "REM ovf"}
    };

    rst = 1'b1;
    alu_control = ALU_ADD;
    rd1 = 32'd0;
    rd2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset running", {31'd0, running}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // A non-M opcode in IDLE must not start anything.
    alu_control = ALU_SUB;
    rd1 = 32'd9;
    rd2 = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("non-M idle running", {31'd0, running}, 32'd0);
    chk("non-M idle done", {31'd0, done}, 32'd0);
    alu_control = ALU_ADD;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 1'b0);
    end

    run_op(ALU_DIV, 32'hFFFF_EAA9, 32'd31, 32'hFFFF_FF50, 33, "DIV with MUL swap", 1'b1);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    alu_control = ALU_DIVU;
    rd1 = 32'd1000;
    rd2 = 32'd3;
    @(posedge clk);
    #1;
    alu_control = ALU_ADD;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset running", {31'd0, running}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid reset running", {31'd0, running}, 32'd0);
    chk("mid reset done", {31'd0, done}, 32'd0);
    chk("mid reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done) saw_done = 1'b1;
      end
      chk("no done after reset", {31'd0, saw_done}, 32'd0);
      chk("idle after reset", {31'd0, running}, 32'd0);
    end
    run_op(ALU_MUL, 32'd20, 32'd5, 32'd100, 2, "MUL after reset", 1'b0);
    run_op(ALU_DIV, 32'hFFFF_EAA9, 32'd31, 32'hFFFF_FF50, 33, "DIV after reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
